// File: rtl/argmax_pkg.sv
// Shared types and helpers for the argmax sequencer: FSM state encoding,
// the most-negative-value constant and the beat count derivation.
package argmax_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FEED,
    DRAIN,
    DONE,
    FLUSH
  } state_e;

  // Most-negative two's-complement value of the given width, sign-extended to 64 bits.
  function automatic logic signed [63:0] neg_max(input int width);
    return -(64'sd1 <<< (width - 1));
  endfunction

  function automatic int beats(input int classes, input int lanes);
    return (classes + lanes - 1) / lanes;
  endfunction

endpackage

// File: rtl/argmax_accum.sv
// Running (best value, best index) register; strict-greater update keeps the earliest index on ties.
// o_nxt_* show the value the register will hold after this cycle's update.
module argmax_accum
  import argmax_pkg::*;
#(
  parameter int pDATA_WIDTH = 16,
  parameter int pIDX_WIDTH  = 6
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          i_clear,
  input  logic                          i_update,
  input  logic signed [pDATA_WIDTH-1:0] i_val,
  input  logic        [pIDX_WIDTH-1:0]  i_idx,
  output logic signed [pDATA_WIDTH-1:0] o_best_val,
  output logic        [pIDX_WIDTH-1:0]  o_best_idx,
  output logic signed [pDATA_WIDTH-1:0] o_nxt_val,
  output logic        [pIDX_WIDTH-1:0]  o_nxt_idx
);

  localparam logic signed [pDATA_WIDTH-1:0] NEG = pDATA_WIDTH'(neg_max(pDATA_WIDTH));

  logic signed [pDATA_WIDTH-1:0] r_best_val;
  logic        [pIDX_WIDTH-1:0]  r_best_idx;
  logic                          w_take;

  assign w_take     = i_update & (i_val > r_best_val);
  assign o_nxt_val  = w_take ? i_val : r_best_val;
  assign o_nxt_idx  = w_take ? i_idx : r_best_idx;
  assign o_best_val = r_best_val;
  assign o_best_idx = r_best_idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_best_val <= NEG;
      r_best_idx <= '0;
    end else if (i_clear) begin
      r_best_val <= NEG;
      r_best_idx <= '0;
    end else if (w_take) begin
      r_best_val <= i_val;
      r_best_idx <= i_idx;
    end
  end

endmodule

// File: rtl/argmax_seq_ctrl.sv
// Streams a logit frame beat-by-beat through a shared max tree and keeps the global argmax.
// ARGMAX_SEQ_PERF_EN adds a 32-bit perf_cycles output counting frame cycles.
module argmax_seq_ctrl
  import argmax_pkg::*;
#(
  parameter int pDATA_WIDTH = 16,
  parameter int pLANES      = 8,
  parameter int pCLASS_NUM  = 64,
  parameter int pTREE_LAT   = 5
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              abort,
  input  logic                              s_valid,
  output logic                              s_ready,
  input  logic [pDATA_WIDTH*pLANES-1:0]     s_data,
  output logic                              tree_en,
  output logic [pDATA_WIDTH*pLANES-1:0]     tree_data,
  input  logic                              tree_valid,
  input  logic signed [pDATA_WIDTH-1:0]     tree_val,
  input  logic [$clog2(pLANES)-1:0]         tree_idx,
  output logic                              m_valid,
  input  logic                              m_ready,
  output logic [$clog2(pCLASS_NUM)-1:0]     m_index,
  output logic [pDATA_WIDTH-1:0]            m_value,
  output logic                              busy
`ifdef ARGMAX_SEQ_PERF_EN
  , output logic [31:0]                     perf_cycles
`endif
);

  localparam int BEATS      = beats(pCLASS_NUM, pLANES);
  localparam int LAST_LANES = pCLASS_NUM - (BEATS - 1) * pLANES;
  localparam int CW         = $clog2(BEATS + 1);
  localparam int FW         = $clog2(pTREE_LAT + 2);
  localparam int IW         = $clog2(pCLASS_NUM);
  localparam logic [CW-1:0] BEATS_C = CW'(BEATS);
  localparam logic [FW-1:0] FL_LAST = FW'(pTREE_LAT);
  localparam logic signed [pDATA_WIDTH-1:0] NEG = pDATA_WIDTH'(neg_max(pDATA_WIDTH));

  state_e r_state, w_state_nxt;
  logic [CW-1:0] r_issued, r_ret_cnt;
  logic [FW-1:0] r_flush_cnt;
  logic          r_m_valid;
  logic [IW-1:0] r_m_index;
  logic [pDATA_WIDTH-1:0] r_m_value;

  logic w_active, w_abort, w_s_ready, w_accept, w_ret, w_ret_last, w_last_beat;
  logic w_done_hs, w_clear;
  logic [IW-1:0] w_gidx;
  logic [pDATA_WIDTH*pLANES-1:0] w_tree_data;
  logic signed [pDATA_WIDTH-1:0] w_best_val, w_nxt_val;
  logic [IW-1:0] w_best_idx, w_nxt_idx;

  assign w_active    = (r_state == FEED) | (r_state == DRAIN);
  assign w_abort     = abort & (w_active | (r_state == DONE));
  // Ready is gated by rst so the interface is quiet for the whole reset pulse.
  assign w_s_ready   = ~rst & ~w_abort &
                       ((r_state == IDLE) | ((r_state == FEED) & (r_issued < BEATS_C)));
  assign w_accept    = s_valid & w_s_ready;
  assign w_ret       = tree_valid & w_active;
  assign w_ret_last  = w_ret & ((r_ret_cnt + 1'b1) == BEATS_C);
  assign w_last_beat = (r_issued == (BEATS_C - 1'b1));
  assign w_done_hs   = (r_state == DONE) & r_m_valid & m_ready;
  assign w_clear     = w_abort | w_done_hs;
  assign w_gidx      = IW'(int'(r_ret_cnt) * pLANES + int'(tree_idx));

  always_comb begin
    w_tree_data = s_data;
    if (w_last_beat) begin
      for (int k = 0; k < pLANES; k++) begin
        if (k >= LAST_LANES) w_tree_data[k*pDATA_WIDTH +: pDATA_WIDTH] = NEG;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:  if (w_accept) w_state_nxt = (BEATS == 1) ? DRAIN : FEED;
      FEED: begin
        if (w_accept & w_last_beat) w_state_nxt = DRAIN;
        if (w_ret_last)             w_state_nxt = DONE;
      end
      DRAIN: if (w_ret_last) w_state_nxt = DONE;
      DONE:  if (w_done_hs) w_state_nxt = IDLE;
      FLUSH: if (r_flush_cnt == FL_LAST) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
    if (w_abort) w_state_nxt = FLUSH;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_issued    <= '0;
      r_ret_cnt   <= '0;
      r_flush_cnt <= '0;
      r_m_valid   <= 1'b0;
      r_m_index   <= '0;
      r_m_value   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_clear)       r_issued <= '0;
      else if (w_accept) r_issued <= r_issued + 1'b1;
      if (w_clear)       r_ret_cnt <= '0;
      else if (w_ret)    r_ret_cnt <= r_ret_cnt + 1'b1;
      r_flush_cnt <= (r_state == FLUSH) ? r_flush_cnt + 1'b1 : '0;
      if (w_clear)         r_m_valid <= 1'b0;
      else if (w_ret_last) r_m_valid <= 1'b1;
      if (w_ret_last & ~w_abort) begin
        r_m_index <= w_nxt_idx;
        r_m_value <= w_nxt_val;
      end
    end
  end

  argmax_accum #(
    .pDATA_WIDTH(pDATA_WIDTH),
    .pIDX_WIDTH (IW)
  ) u_accum (
    .clk       (clk),
    .rst       (rst),
    .i_clear   (w_clear),
    .i_update  (w_ret & ~w_abort),
    .i_val     (tree_val),
    .i_idx     (w_gidx),
    .o_best_val(w_best_val),
    .o_best_idx(w_best_idx),
    .o_nxt_val (w_nxt_val),
    .o_nxt_idx (w_nxt_idx)
  );

`ifdef ARGMAX_SEQ_PERF_EN
  logic [31:0] r_perf;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                 r_perf <= '0;
    else if ((r_state == IDLE) & w_accept)   r_perf <= 32'd1;
    else if (w_active & (r_perf != '1))      r_perf <= r_perf + 32'd1;
  end
  assign perf_cycles = r_perf;
`endif

  assign s_ready   = w_s_ready;
  assign tree_en   = w_accept;
  assign tree_data = w_tree_data;
  assign m_valid   = r_m_valid;
  assign m_index   = r_m_index;
  assign m_value   = r_m_value;
  assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_argmax_seq_ctrl.sv
// Directed bench for argmax_seq_ctrl: a 64-class and a 20-class instance, each fed by a 5-cycle tree model.
module tb_argmax_seq_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- instance A: 64 classes ----------------
  logic         a_abort, a_s_valid, a_s_ready, a_tree_en, a_tree_valid, a_m_valid, a_m_ready, a_busy;
  logic [127:0] a_s_data, a_tree_data;
  logic [15:0]  a_tree_val, a_m_value;
  logic [2:0]   a_tree_idx;
  logic [5:0]   a_m_index;

  argmax_seq_ctrl #(.pDATA_WIDTH(16), .pLANES(8), .pCLASS_NUM(64), .pTREE_LAT(5)) u_a (
    .clk(clk), .rst(rst), .abort(a_abort), .s_valid(a_s_valid), .s_ready(a_s_ready),
    .s_data(a_s_data), .tree_en(a_tree_en), .tree_data(a_tree_data), .tree_valid(a_tree_valid),
    .tree_val(a_tree_val), .tree_idx(a_tree_idx), .m_valid(a_m_valid), .m_ready(a_m_ready),
    .m_index(a_m_index), .m_value(a_m_value), .busy(a_busy)
  );

  // ---------------- instance B: 20 classes ----------------
  logic         b_abort, b_s_valid, b_s_ready, b_tree_en, b_tree_valid, b_m_valid, b_m_ready, b_busy;
  logic [127:0] b_s_data, b_tree_data;
  logic [15:0]  b_tree_val, b_m_value;
  logic [2:0]   b_tree_idx;
  logic [4:0]   b_m_index;

  argmax_seq_ctrl #(.pDATA_WIDTH(16), .pLANES(8), .pCLASS_NUM(20), .pTREE_LAT(5)) u_b (
    .clk(clk), .rst(rst), .abort(b_abort), .s_valid(b_s_valid), .s_ready(b_s_ready),
    .s_data(b_s_data), .tree_en(b_tree_en), .tree_data(b_tree_data), .tree_valid(b_tree_valid),
    .tree_val(b_tree_val), .tree_idx(b_tree_idx), .m_valid(b_m_valid), .m_ready(b_m_ready),
    .m_index(b_m_index), .m_value(b_m_value), .busy(b_busy)
  );

  // ---------------- tree models (lowest lane wins ties) ----------------
  function automatic logic [18:0] tmax(input logic [127:0] d);
    logic signed [15:0] v;
    logic [2:0] ix;
    v = d[15:0];
    ix = 3'd0;
    for (int k = 1; k < 8; k++) begin
      if ($signed(d[k*16 +: 16]) > v) begin
        v  = d[k*16 +: 16];
        ix = 3'(k);
      end
    end
    return {ix, v};
  endfunction

  logic [18:0] a_res, b_res;
  assign a_res = tmax(a_tree_data);
  assign b_res = tmax(b_tree_data);
  logic        a_pv[5], b_pv[5];
  logic [18:0] a_pd[5], b_pd[5];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 5; i++) begin
        a_pv[i] <= 1'b0; a_pd[i] <= '0; b_pv[i] <= 1'b0; b_pd[i] <= '0;
      end
    end else begin
      a_pv[0] <= a_tree_en; a_pd[0] <= a_res;
      b_pv[0] <= b_tree_en; b_pd[0] <= b_res;
      for (int i = 1; i < 5; i++) begin
        a_pv[i] <= a_pv[i-1]; a_pd[i] <= a_pd[i-1];
        b_pv[i] <= b_pv[i-1]; b_pd[i] <= b_pd[i-1];
      end
    end
  end
  assign a_tree_valid = a_pv[4];
  assign a_tree_idx   = a_pd[4][18:16];
  assign a_tree_val   = a_pd[4][15:0];
  assign b_tree_valid = b_pv[4];
  assign b_tree_idx   = b_pd[4][18:16];
  assign b_tree_val   = b_pd[4][15:0];

  // ---------------- A helpers ----------------
  logic signed [15:0] a_frame[64];

  function automatic logic [127:0] pack_a(input int b);
    logic [127:0] r;
    for (int k = 0; k < 8; k++) r[k*16 +: 16] = a_frame[b*8 + k];
    return r;
  endfunction

  task automatic fill_a(input int base);
    for (int i = 0; i < 64; i++) a_frame[i] = 16'(base);
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic a_beat(input int b, output int acc);
    int t;
    a_s_data  = pack_a(b);
    a_s_valid = 1'b1;
    t = 0;
    #1;
    while (!a_s_ready && t < 50) begin
      @(negedge clk); #1; t++;
    end
    n_tests++;
    if (t >= 50) begin
      n_fail++;
      $display("FAIL a_beat_timeout beat=%0d got s_ready=0 exp 1", b);
    end
    acc = cyc;
    @(negedge clk);
    a_s_valid = 1'b0;
  endtask

  task automatic a_send(input int nbeats, input int gap_max, output int last_acc);
    for (int b = 0; b < nbeats; b++) begin
      repeat ($urandom_range(gap_max, 0)) @(negedge clk);
      a_beat(b, last_acc);
    end
  endtask

  task automatic a_result(input string nm, input int last_acc, input int exp_idx, input int exp_val);
    int t;
    t = 0;
    while (!a_m_valid && t < 100) begin
      @(negedge clk); t++;
    end
    n_tests++;
    if (!a_m_valid) begin
      n_fail++;
      $display("FAIL %s_timeout got m_valid=0 exp 1", nm);
      return;
    end
    n_tests++;
    if (cyc - last_acc !== 6) begin
      n_fail++; $display("FAIL %s_latency got=%0d exp=6", nm, cyc - last_acc);
    end
    n_tests++;
    if (a_m_index !== 6'(exp_idx)) begin
      n_fail++; $display("FAIL %s_index got=%0d exp=%0d", nm, a_m_index, exp_idx);
    end
    n_tests++;
    if (a_m_value !== 16'(exp_val)) begin
      n_fail++; $display("FAIL %s_value got=%0d exp=%0d", nm, $signed(a_m_value), exp_val);
    end
  endtask

  task automatic a_handshake(input string nm);
    a_m_ready = 1'b1;
    @(negedge clk);
    a_m_ready = 1'b0;
    n_tests++;
    if (a_m_valid !== 1'b0 || a_busy !== 1'b0) begin
      n_fail++; $display("FAIL %s_handshake got m_valid=%b busy=%b exp 0 0", nm, a_m_valid, a_busy);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    @(negedge clk);
    n_tests++;
    if ({a_s_ready, a_tree_en, a_m_valid, a_busy, b_s_ready, b_busy} !== 6'b0) begin
      n_fail++; $display("FAIL reset_ctrl got=%b exp=000000",
                         {a_s_ready, a_tree_en, a_m_valid, a_busy, b_s_ready, b_busy});
    end
    n_tests++;
    if (a_m_index !== 6'd0 || a_m_value !== 16'd0) begin
      n_fail++; $display("FAIL reset_result got idx=%0d val=%0d exp 0 0", a_m_index, a_m_value);
    end
    rst = 1'b0;
    #1;
    n_tests++;
    if (a_s_ready !== 1'b1 || b_s_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_idle_ready got a=%b b=%b exp 1 1", a_s_ready, b_s_ready);
    end
    @(negedge clk);
  endtask

  task automatic test_basic();
    int acc;
    for (int i = 0; i < 64; i++) a_frame[i] = 16'(int'($urandom_range(2398, 0)) - 1199);
    a_frame[37] = 16'sd1200;
    a_send(8, 0, acc);
    a_result("basic", acc, 37, 1200);
    a_handshake("basic");
  endtask

  task automatic test_pad();
    int acc, t;
    logic [15:0] neg30k;
    neg30k = 16'hFFFF - 16'd29999;
    for (int b = 0; b < 3; b++) begin
      for (int k = 0; k < 8; k++) b_s_data[k*16 +: 16] = (b == 2 && k >= 4) ? 16'h7FFF : neg30k;
      b_s_valid = 1'b1;
      t = 0;
      #1;
      while (!b_s_ready && t < 50) begin
        @(negedge clk); #1; t++;
      end
      if (b == 2) begin
        n_tests++;
        if (b_tree_en !== 1'b1) begin
          n_fail++; $display("FAIL pad_tree_en got=%b exp=1", b_tree_en);
        end
        for (int k = 0; k < 8; k++) begin
          n_tests++;
          if (b_tree_data[k*16 +: 16] !== ((k >= 4) ? 16'h8000 : neg30k)) begin
            n_fail++; $display("FAIL pad_lane%0d got=%h exp=%h", k, b_tree_data[k*16 +: 16],
                               (k >= 4) ? 16'h8000 : neg30k);
          end
        end
      end
      acc = cyc;
      @(negedge clk);
      b_s_valid = 1'b0;
    end
    t = 0;
    while (!b_m_valid && t < 100) begin
      @(negedge clk); t++;
    end
    n_tests++;
    if (!b_m_valid || cyc - acc !== 6) begin
      n_fail++; $display("FAIL pad_latency got m_valid=%b lat=%0d exp 1 6", b_m_valid, cyc - acc);
    end
    n_tests++;
    if (b_m_value !== neg30k || b_m_index > 5'd19) begin
      n_fail++; $display("FAIL pad_result got val=%0d idx=%0d exp val=-30000 idx<=19",
                         $signed(b_m_value), b_m_index);
    end
    b_m_ready = 1'b1;
    @(negedge clk);
    b_m_ready = 1'b0;
    n_tests++;
    if (b_m_valid !== 1'b0 || b_busy !== 1'b0) begin
      n_fail++; $display("FAIL pad_handshake got m_valid=%b busy=%b exp 0 0", b_m_valid, b_busy);
    end
  endtask

  task automatic test_tie();
    int acc;
    fill_a(-100);
    a_frame[20] = 16'sd499;
    a_frame[3]  = 16'sd500;
    a_frame[50] = 16'sd500;
    a_send(8, 0, acc);
    a_result("tie", acc, 3, 500);
    a_handshake("tie");
  endtask

  task automatic test_back_to_back();
    int acc;
    fill_a(-7);
    a_frame[60] = 16'sd2000;
    a_send(8, 3, acc);
    a_result("gap", acc, 60, 2000);
    a_s_data  = pack_a(0);
    a_s_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      n_tests++;
      if (a_m_valid !== 1'b1 || a_m_index !== 6'd60 || a_m_value !== 16'd2000 ||
          a_s_ready !== 1'b0 || a_tree_en !== 1'b0) begin
        n_fail++;
        $display("FAIL hold_cycle%0d got v=%b idx=%0d val=%0d rdy=%b en=%b exp 1 60 2000 0 0",
                 i, a_m_valid, a_m_index, a_m_value, a_s_ready, a_tree_en);
      end
      @(negedge clk);
    end
    a_s_valid = 1'b0;
    a_handshake("gap");
    fill_a(5);
    a_frame[9] = 16'sd77;
    a_send(8, 2, acc);
    a_result("second", acc, 9, 77);
    a_handshake("second");
  endtask

  task automatic test_abort();
    int acc;
    bit seen_tv;
    fill_a(0);
    a_frame[5] = 16'sd30000;
    a_send(4, 0, acc);
    a_abort   = 1'b1;
    a_s_data  = pack_a(4);
    a_s_valid = 1'b1;
    #1;
    n_tests++;
    if (a_s_ready !== 1'b0 || a_tree_en !== 1'b0) begin
      n_fail++; $display("FAIL abort_priority got rdy=%b en=%b exp 0 0", a_s_ready, a_tree_en);
    end
    @(negedge clk);
    a_abort   = 1'b0;
    a_s_valid = 1'b0;
    seen_tv   = 1'b0;
    for (int i = 0; i < 6; i++) begin
      #1;
      seen_tv = seen_tv | a_tree_valid;
      n_tests++;
      if (a_s_ready !== 1'b0 || a_busy !== 1'b1 || a_m_valid !== 1'b0) begin
        n_fail++; $display("FAIL flush_cycle%0d got rdy=%b busy=%b v=%b exp 0 1 0",
                           i, a_s_ready, a_busy, a_m_valid);
      end
      @(negedge clk);
    end
    #1;
    n_tests++;
    if (a_s_ready !== 1'b1 || a_busy !== 1'b0 || !seen_tv) begin
      n_fail++; $display("FAIL flush_exit got rdy=%b busy=%b late_tv=%b exp 1 0 1",
                         a_s_ready, a_busy, seen_tv);
    end
    fill_a(-3);
    a_frame[44] = 16'sd100;
    a_send(8, 0, acc);
    a_result("post_abort", acc, 44, 100);
    a_handshake("post_abort");
  endtask

  task automatic test_reset_mid();
    int acc;
    fill_a(-1);
    a_frame[63] = 16'sd9;
    a_send(8, 0, acc);
    @(negedge clk);
    @(negedge clk);
    n_tests++;
    if (a_busy !== 1'b1 || a_m_valid !== 1'b0) begin
      n_fail++; $display("FAIL drain_setup got busy=%b v=%b exp 1 0", a_busy, a_m_valid);
    end
    #2 rst = 1'b1;
    #1;
    n_tests++;
    if (a_busy !== 1'b0 || a_s_ready !== 1'b0 || a_m_valid !== 1'b0 || a_m_index !== 6'd0) begin
      n_fail++; $display("FAIL async_rst got busy=%b rdy=%b v=%b idx=%0d exp 0 0 0 0",
                         a_busy, a_s_ready, a_m_valid, a_m_index);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    a_send(8, 0, acc);
    a_result("after_rst", acc, 63, 9);
    a_handshake("after_rst");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    a_abort = 1'b0; a_s_valid = 1'b0; a_m_ready = 1'b0; a_s_data = '0;
    b_abort = 1'b0; b_s_valid = 1'b0; b_m_ready = 1'b0; b_s_data = '0;
    test_reset();
    test_basic();
    test_pad();
    test_tie();
    test_back_to_back();
    test_abort();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
